// File: rtl/dma_sync_pkg.sv
// Shared constants and types for the toggle-based DMA request CDC receivers.
package dma_sync_pkg;

  localparam int unsigned DMA_CNT_W    = 4;
  localparam logic        DMA_ACK_INIT = 1'b0;

  typedef logic [DMA_CNT_W-1:0] pend_cnt_t;

endpackage

// File: rtl/dma_req_toggle_rx_if.sv
// Valid/ready request handshake between the toggle receiver and the DMA engine.
interface dma_req_toggle_rx_if;

  logic req_valid;
  logic req_ready;

  modport master (output req_valid, input  req_ready);
  modport slave  (input  req_valid, output req_ready);

endinterface

// File: rtl/dma_req_toggle_rx_tgl_edge_det.sv
// Toggle-level change detector: one-cycle event on every rising or falling transition.
module tgl_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl_i,
  output logic req_evt_o
);

  logic tgl_q;

  always_ff @(posedge clk) begin
    if (rst) tgl_q <= RST_VAL;
    else     tgl_q <= tgl_i;
  end

  assign req_evt_o = tgl_i ^ tgl_q;

endmodule

// File: rtl/dma_req_toggle_rx.sv
// DMA-domain request receiver: queues toggle events as pending requests and returns an ack toggle.
module dma_req_toggle_rx
  import dma_sync_pkg::*;
#(
  parameter int unsigned CNT_W    = DMA_CNT_W,
  parameter logic        ACK_INIT = DMA_ACK_INIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_tgl_i,
  dma_req_toggle_rx_if.master      req_if,
  output logic                     ack_tgl_o,
  output logic [CNT_W-1:0]         pend_cnt_o,
  output logic                     ovf_o,
  input  logic                     ovf_clr_i,
  output logic                     busy_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic             ovf_q, ovf_d;
  logic             ack_q, ack_d;
  logic             ack_pend_q, ack_pend_d;
  logic             req_evt;
  logic             valid;
  logic             acc;

  tgl_edge_det #(.RST_VAL(1'b0)) u_edge (
    .clk       (clk),
    .rst       (rst),
    .tgl_i     (req_tgl_i),
    .req_evt_o (req_evt)
  );

  // valid comes straight from the counter register, so ready never reaches it
  assign valid = (pend_cnt_q != '0);
  assign acc   = valid & req_if.req_ready;

  always_comb begin
    pend_cnt_d = pend_cnt_q;
    ovf_d      = ovf_q & ~ovf_clr_i;
    ack_d      = ack_q ^ acc;
    ack_pend_d = acc;
    if (req_evt && !acc) begin
      if (pend_cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                       pend_cnt_d = pend_cnt_q + CNT_ONE;
    end else if (!req_evt && acc) begin
      pend_cnt_d = pend_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt_q <= '0;
      ovf_q      <= 1'b0;
      ack_q      <= ACK_INIT;
      ack_pend_q <= 1'b0;
    end else begin
      pend_cnt_q <= pend_cnt_d;
      ovf_q      <= ovf_d;
      ack_q      <= ack_d;
      ack_pend_q <= ack_pend_d;
    end
  end

  assign req_if.req_valid = valid;
  assign ack_tgl_o        = ack_q;
  assign pend_cnt_o       = pend_cnt_q;
  assign ovf_o            = ovf_q;
  assign busy_o           = valid | ack_pend_q;

endmodule

// File: tb/tb_dma_req_toggle_rx.sv
// Directed bench for dma_req_toggle_rx with CNT_W=4, ACK_INIT=0.
module tb_dma_req_toggle_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_tgl;
  logic       ack_tgl;
  logic [3:0] pend_cnt;
  logic       ovf;
  logic       ovf_clr;
  logic       busy;
  logic       exp_ack;
  int unsigned checks = 0;
  int unsigned errors = 0;

  dma_req_toggle_rx_if bus ();

  dma_req_toggle_rx #(.CNT_W(4), .ACK_INIT(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_tgl_i  (req_tgl),
    .req_if     (bus),
    .ack_tgl_o  (ack_tgl),
    .pend_cnt_o (pend_cnt),
    .ovf_o      (ovf),
    .ovf_clr_i  (ovf_clr),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_tgl = 1'b0; bus.req_ready = 1'b0; ovf_clr = 1'b0;
    exp_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_cnt",   32'(pend_cnt), 0);
    chk("rst_valid", 32'(bus.req_valid), 0);
    chk("rst_ack",   32'(ack_tgl), 0);
    chk("rst_ovf",   32'(ovf), 0);
    chk("rst_busy",  32'(busy), 0);

    // single toggle with ready held high
    bus.req_ready = 1'b1; req_tgl = 1'b1;
    step();
    chk("t1_cnt",   32'(pend_cnt), 1);
    chk("t1_valid", 32'(bus.req_valid), 1);
    chk("t1_ack0",  32'(ack_tgl), 0);
    step();
    chk("t1_cnt0",  32'(pend_cnt), 0);
    chk("t1_ack1",  32'(ack_tgl), 1);
    chk("t1_busy",  32'(busy), 1);
    step();
    chk("t1_idle",  32'(busy), 0);
    chk("t1_vld0",  32'(bus.req_valid), 0);
    chk("t1_ackh",  32'(ack_tgl), 1);
    exp_ack = 1'b1;

    // backpressure burst of five toggles, then five back-to-back accepts
    bus.req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_tgl = ~req_tgl;
      step();
      chk("t2_fill", 32'(pend_cnt), 32'(i + 1));
    end
    bus.req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      exp_ack = ~exp_ack;
      chk("t2_drain", 32'(pend_cnt), 32'(4 - i));
      chk("t2_ack",   32'(ack_tgl), 32'(exp_ack));
    end
    step();
    chk("t2_noacc", 32'(ack_tgl), 0);
    bus.req_ready = 1'b0;

    // event and accept in the same cycle
    for (int i = 0; i < 3; i++) begin
      req_tgl = ~req_tgl;
      step();
    end
    chk("t3_pre", 32'(pend_cnt), 3);
    bus.req_ready = 1'b1; req_tgl = ~req_tgl;
    step();
    chk("t3_cnt", 32'(pend_cnt), 3);
    chk("t3_ack", 32'(ack_tgl), 1);
    bus.req_ready = 1'b0;
    step();
    chk("t3_hold", 32'(ack_tgl), 1);
    bus.req_ready = 1'b1;
    step(); step(); step();
    chk("t3_empty", 32'(pend_cnt), 0);
    chk("t3_ack3",  32'(ack_tgl), 0);
    bus.req_ready = 1'b0;

    // overflow: 15 fill, 16th dropped, clear loses to a simultaneous drop
    for (int i = 0; i < 15; i++) begin
      req_tgl = ~req_tgl;
      step();
    end
    chk("t4_full", 32'(pend_cnt), 15);
    chk("t4_ovf0", 32'(ovf), 0);
    req_tgl = ~req_tgl;
    step();
    chk("t4_cnt16", 32'(pend_cnt), 15);
    chk("t4_ovf1",  32'(ovf), 1);
    req_tgl = ~req_tgl; ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t4_setwin", 32'(ovf), 1);
    chk("t4_cnt17",  32'(pend_cnt), 15);
    step();
    chk("t4_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t4_clr",  32'(ovf), 0);
    chk("t4_ack",  32'(ack_tgl), 0);

    // drain to 7 (8 accepts: ack ends where it started), then reset mid-stream
    bus.req_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    bus.req_ready = 1'b0;
    chk("t5_pre",  32'(pend_cnt), 7);
    chk("t5_ack",  32'(ack_tgl), 0);
    bus.req_ready = 1'b1;
    step();
    chk("t5_ack1", 32'(ack_tgl), 1);
    chk("t5_cnt6", 32'(pend_cnt), 6);
    bus.req_ready = 1'b0;
    rst = 1'b1; req_tgl = 1'b0;
    step();
    rst = 1'b0;
    chk("t5_cnt",   32'(pend_cnt), 0);
    chk("t5_valid", 32'(bus.req_valid), 0);
    chk("t5_ackrst", 32'(ack_tgl), 0);
    step();
    chk("t5_noevt", 32'(pend_cnt), 0);
    chk("t5_busy",  32'(busy), 0);

    // ready with nothing pending must not accept
    bus.req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_cnt", 32'(pend_cnt), 0);
      chk("t6_ack", 32'(ack_tgl), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
